// File: rtl/alu_writeback_stage.sv
// Registered stage after the ALU: holds the architectural accumulator and flags, and
// queues register-file writebacks in a circular FIFO drained under a valid/ready handshake.
module alu_writeback_stage #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int RA    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_result,
  input  logic [3:0]                 in_flags,
  input  logic                       in_acc_we,
  input  logic                       in_flag_we,
  input  logic                       in_rf_we,
  input  logic [RA-1:0]              in_dest,
  output logic [W-1:0]               acc_q,
  output logic [3:0]                 flags_q,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [W-1:0]               wb_data,
  output logic [RA-1:0]              wb_addr,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                stall_cnt,
  input  logic                       clr_stats
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  data_mem [DEPTH];
  logic [RA-1:0] addr_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic accept, push, pop;

  // Ready depends only on occupancy, so there is no combinational path from wb_ready.
  assign in_ready   = (count != CW'(DEPTH));
  assign accept     = in_valid & in_ready;
  assign push       = accept & in_rf_we;
  assign wb_valid   = (count != '0);
  assign pop        = wb_valid & wb_ready;
  assign fifo_count = count;

  // Masking the stale head keeps the writeback port at zero whenever the queue is empty.
  assign wb_data = wb_valid ? data_mem[rd_ptr] : '0;
  assign wb_addr = wb_valid ? addr_mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      flags_q <= '0;
    end else if (accept) begin
      if (in_acc_we)  acc_q   <= in_result;
      if (in_flag_we) flags_q <= in_flags;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count, so old contents are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= in_result;
      addr_mem[wr_ptr] <= in_dest;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the accumulator, flags and writeback order.
module tb_alu_writeback_stage;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int RA    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_result;
  logic [3:0]    in_flags;
  logic          in_acc_we, in_flag_we, in_rf_we;
  logic [RA-1:0] in_dest;
  logic [W-1:0]  acc_q;
  logic [3:0]    flags_q;
  logic          wb_valid, wb_ready;
  logic [W-1:0]  wb_data;
  logic [RA-1:0] wb_addr;
  logic [CW-1:0] fifo_count;
  logic [15:0]   stall_cnt;
  logic          clr_stats;

  alu_writeback_stage #(.W(W), .DEPTH(DEPTH), .RA(RA)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_flags(in_flags),
    .in_acc_we(in_acc_we), .in_flag_we(in_flag_we), .in_rf_we(in_rf_we), .in_dest(in_dest),
    .acc_q(acc_q), .flags_q(flags_q),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr),
    .fifo_count(fifo_count), .stall_cnt(stall_cnt), .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RA-1:0] addr;
    logic [W-1:0]  data;
  } wb_t;

  wb_t          m_q[$];
  logic [W-1:0] m_acc;
  logic [3:0]   m_flags;
  int           m_stall;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_acc   = '0;
    m_flags = '0;
    m_stall = 0;
  endtask

  // Applies the stage's rules to the inputs present just before the coming edge.
  task automatic model_edge();
    bit  full, acc, pop;
    wb_t e;
    full = (m_q.size() == DEPTH);
    acc  = in_valid && !full;
    pop  = (m_q.size() > 0) && wb_ready;
    if (clr_stats) m_stall = 0;
    else if (in_valid && full && m_stall < 65535) m_stall++;
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      if (in_acc_we)  m_acc   = in_result;
      if (in_flag_we) m_flags = in_flags;
      if (in_rf_we) begin
        e.addr = in_dest;
        e.data = in_result;
        m_q.push_back(e);
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".ready"}, 32'(in_ready),   32'(m_q.size() != DEPTH));
    check({tag, ".valid"}, 32'(wb_valid),   32'(m_q.size() != 0));
    check({tag, ".count"}, 32'(fifo_count), 32'(m_q.size()));
    check({tag, ".acc"},   32'(acc_q),      32'(m_acc));
    check({tag, ".flags"}, 32'(flags_q),    32'(m_flags));
    check({tag, ".stall"}, 32'(stall_cnt),  32'(m_stall));
    if (m_q.size() != 0) begin
      check({tag, ".wb_data"}, 32'(wb_data), 32'(m_q[0].data));
      check({tag, ".wb_addr"}, 32'(wb_addr), 32'(m_q[0].addr));
    end
  endtask

  task automatic tick(input string tag, input bit do_check);
    model_edge();
    @(posedge clk);
    #1;
    if (do_check) compare_all(tag);
  endtask

  task automatic drive(input bit v, input logic [W-1:0] r, input logic [3:0] f,
                       input bit awe, input bit fwe, input bit rwe, input logic [RA-1:0] d);
    in_valid   = v;
    in_result  = r;
    in_flags   = f;
    in_acc_we  = awe;
    in_flag_we = fwe;
    in_rf_we   = rwe;
    in_dest    = d;
  endtask

  task automatic single_accept(input string tag);
    drive(1'b1, 16'(32 >> 5), 4'b0000, 1'b1, 1'b1, 1'b1, 3'd3);
    wb_ready = 1'b0;
    tick(tag, 1'b1);
    check({tag, ".acc1"},   32'(acc_q),      32'd1);
    check({tag, ".wbv1"},   32'(wb_valid),   32'd1);
    check({tag, ".wbd1"},   32'(wb_data),    32'd1);
    check({tag, ".wba3"},   32'(wb_addr),    32'd3);
    check({tag, ".cnt1"},   32'(fifo_count), 32'd1);
    in_valid = 1'b0;
    wb_ready = 1'b1;
    tick(tag, 1'b1);
    check({tag, ".wbv0"},   32'(wb_valid),   32'd0);
    check({tag, ".cnt0"},   32'(fifo_count), 32'd0);
    wb_ready = 1'b0;
  endtask

  logic [W-1:0] popped[$];

  initial begin
    rst_n     = 1'b0;
    wb_ready  = 1'b0;
    clr_stats = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    model_reset();
    #22;
    check("rst.acc",   32'(acc_q),      32'd0);
    check("rst.flags", 32'(flags_q),    32'd0);
    check("rst.valid", 32'(wb_valid),   32'd0);
    check("rst.count", 32'(fifo_count), 32'd0);
    check("rst.data",  32'(wb_data),    32'd0);
    check("rst.addr",  32'(wb_addr),    32'd0);
    check("rst.stall", 32'(stall_cnt),  32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.ready", 32'(in_ready), 32'd1);

    single_accept("s1");

    // Fill to full, then stall three cycles while the accumulator must hold.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(10 * (i + 1)), 4'(i), 1'b1, 1'b1, 1'b1, 3'(i + 1));
      tick("fill", 1'b1);
    end
    check("fill.ready0", 32'(in_ready),   32'd0);
    check("fill.cnt4",   32'(fifo_count), 32'd4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'd999, 4'hF, 1'b1, 1'b1, 1'b1, 3'd7);
      tick("stall", 1'b1);
    end
    check("stall.cnt3",  32'(stall_cnt), 32'd3);
    check("stall.acc40", 32'(acc_q),     32'd40);
    in_valid = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain.data", 32'(wb_data), 32'(10 * (i + 1)));
      check("drain.addr", 32'(wb_addr), 32'(i + 1));
      tick("drain", 1'b1);
    end
    check("drain.empty", 32'(wb_valid), 32'd0);

    // Back-to-back accepts with a ready consumer exercise pointer wrap.
    wb_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(1'b1, 16'(100 + i), 4'h0, 1'b0, 1'b0, 1'b1, 3'(i % 8));
      else        in_valid = 1'b0;
      if (wb_valid) popped.push_back(wb_data);
      tick("wrap", 1'b1);
      check("wrap.cnt_le2", 32'(fifo_count <= 2), 32'd1);
    end
    check("wrap.npop", 32'(popped.size()), 32'd10);
    for (int i = 0; i < popped.size(); i++) check("wrap.order", 32'(popped[i]), 32'(100 + i));
    wb_ready = 1'b0;

    // Enable masking and an all-disabled accept.
    drive(1'b1, 16'h0123, 4'b1010, 1'b0, 1'b1, 1'b0, 3'd0);
    tick("mask.flags", 1'b1);
    drive(1'b1, 16'hFFF3, 4'b0101, 1'b1, 1'b0, 1'b0, 3'd5);
    tick("mask.acc", 1'b1);
    check("mask.acc",   32'(acc_q),      32'h0000FFF3);
    check("mask.flags", 32'(flags_q),    32'b1010);
    check("mask.count", 32'(fifo_count), 32'd0);
    drive(1'b1, 16'h5555, 4'b1111, 1'b0, 1'b0, 1'b0, 3'd2);
    tick("noop", 1'b1);

    // Asynchronous reset between edges with entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(200 + i), 4'h3, 1'b1, 1'b1, 1'b1, 3'(i));
      tick("pre_rst", 1'b1);
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.valid", 32'(wb_valid),   32'd0);
    check("arst.acc",   32'(acc_q),      32'd0);
    check("arst.count", 32'(fifo_count), 32'd0);
    check("arst.flags", 32'(flags_q),    32'd0);
    check("arst.data",  32'(wb_data),    32'd0);
    #2;
    rst_n = 1'b1;
    tick("post_rst", 1'b1);
    single_accept("s5");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom));
      wb_ready  = 1'($urandom_range(0, 2) == 0);
      clr_stats = 1'($urandom_range(0, 31) == 0);
      tick("rand", 1'b1);
    end
    clr_stats = 1'b0;

    // Saturation of the stall counter, then a clear during stall.
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(i), 4'h0, 1'b0, 1'b0, 1'b1, 3'd1);
      tick("sat_fill", 1'b1);
    end
    check("sat.full", 32'(in_ready), 32'd0);
    clr_stats = 1'b1;
    tick("sat_clr0", 1'b1);
    clr_stats = 1'b0;
    for (int i = 0; i < 65540; i++) tick("sat", 1'b0);
    compare_all("sat");
    check("sat.ffff", 32'(stall_cnt), 32'h0000FFFF);
    clr_stats = 1'b1;
    tick("clr", 1'b1);
    check("clr.zero", 32'(stall_cnt), 32'd0);
    clr_stats = 1'b0;
    tick("clr_inc", 1'b1);
    check("clr.one", 32'(stall_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
